alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, datapath width of operands and result.
REQ-002 SHALL have parameter OPCODE_WIDTH, default 4, ALU opcode width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1  requester N presents an operation.
REQ-006 SHALL have ports req0_operand1/req1_operand1, req0_operand2/req1_operand2  input  WORD_WIDTH  operands of requester N.
REQ-007 SHALL have ports req0_opCode/req1_opCode  input  OPCODE_WIDTH  operation of requester N.
REQ-008 SHALL have ports req0_ready/req1_ready  output  1  requester N's operation accepted this cycle.
REQ-009 SHALL have ports resp0_valid/resp1_valid  output  1  result pending for requester N.
REQ-010 SHALL have ports resp0_result/resp1_result  output  WORD_WIDTH, resp0_zero_flag/resp1_zero_flag  output  1  captured ALU outputs.
REQ-011 SHALL have ports resp0_ready/resp1_ready  input  1  requester N consumes its response.
REQ-012 SHALL have ports alu_operand1, alu_operand2  output  WORD_WIDTH; alu_opCode  output  OPCODE_WIDTH  drive of the shared combinational alu.
REQ-013 SHALL have ports alu_result  input  WORD_WIDTH; alu_zero_flag  input  1  outputs of the shared alu.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port op_count  output  16  number of completed operations, wraps 0xFFFF->0x0000.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-017 In IDLE, reqN_ready SHALL be combinationally high only for the requester selected by arbitration; both low outside IDLE.
REQ-018 Arbitration SHALL be round-robin: single valid requester wins; both valid -> requester other than last_grant wins.
REQ-019 Acceptance (valid && ready) SHALL latch operand1, operand2, opCode into operand registers, record grant id, set last_grant, and go IDLE->EXEC.
REQ-020 No valid request in IDLE SHALL keep FSM in IDLE with all registers held.
REQ-021 alu_operand1/alu_operand2/alu_opCode SHALL be driven directly from the operand registers, holding last values between operations.
REQ-022 EXEC SHALL last exactly one cycle; at its closing edge alu_result and alu_zero_flag SHALL be captured into the response registers and FSM SHALL enter RESP.
REQ-023 In RESP, respN_valid SHALL be high only for the granted requester; the other's resp_valid stays low.
REQ-024 resp_result/resp_zero_flag SHALL stay stable while resp_valid is high and resp_ready is low.
REQ-025 On respN_valid && respN_ready, FSM SHALL return to IDLE next edge and op_count SHALL increment by 1.
REQ-026 Latency SHALL be: accept at edge T, resp_valid high from cycle after edge T+1; best-case throughput one operation per 3 cycles.
REQ-027 Requests arriving during EXEC/RESP SHALL be ignored (not acknowledged) until IDLE; requesters hold valid.
REQ-028 resp_ready of the non-granted requester SHALL have no effect.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, last_grant=1 (requester 0 wins first tie), operand registers and alu_* outputs 0, response registers 0, all resp_valid 0, busy 0, op_count 0.
REQ-030 Reset asserted in EXEC or RESP SHALL abort the operation; no response is delivered and op_count is not incremented.
REQ-031 After rst_n rises, first acceptance SHALL be possible at the first rising edge.

Verification
REQ-032 Bench SHALL model the alu as result=operand1+operand2, zero_flag=(result==0) and cover:
REQ-033 Single: req0 valid, 0x12,0x34,op 0 -> req0_ready same cycle, alu_operand1=0x12 next cycle, resp0_valid with 0x46, zero 0 two cycles after accept; op_count 1.
REQ-034 Tie: both valid after reset -> req0 first, req1 second, req0 third (alternation); resp never on wrong port.
REQ-035 Backpressure: resp1_ready low 5 cycles -> resp1_valid, result held constant, busy 1, req0 not acknowledged; released -> IDLE next cycle.
REQ-036 Zero/wrap: 0xFF+0x01 -> resp result 0x00, zero_flag 1; op_count preloaded by 65535 ops wraps to 0.
REQ-037 Reset in EXEC: assert rst_n low mid-cycle -> all outputs to reset values asynchronously, no resp_valid after release, op_count 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU.
// Round-robin grant, one operation in flight, response held until consumed.
module alu_arbiter #(
  parameter int unsigned WORD_WIDTH   = 8,
  parameter int unsigned OPCODE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // requester 0
  input  logic                    req0_valid,
  input  logic [WORD_WIDTH-1:0]   req0_operand1,
  input  logic [WORD_WIDTH-1:0]   req0_operand2,
  input  logic [OPCODE_WIDTH-1:0] req0_opCode,
  output logic                    req0_ready,
  output logic                    resp0_valid,
  output logic [WORD_WIDTH-1:0]   resp0_result,
  output logic                    resp0_zero_flag,
  input  logic                    resp0_ready,
  // requester 1
  input  logic                    req1_valid,
  input  logic [WORD_WIDTH-1:0]   req1_operand1,
  input  logic [WORD_WIDTH-1:0]   req1_operand2,
  input  logic [OPCODE_WIDTH-1:0] req1_opCode,
  output logic                    req1_ready,
  output logic                    resp1_valid,
  output logic [WORD_WIDTH-1:0]   resp1_result,
  output logic                    resp1_zero_flag,
  input  logic                    resp1_ready,
  // shared alu
  output logic [WORD_WIDTH-1:0]   alu_operand1,
  output logic [WORD_WIDTH-1:0]   alu_operand2,
  output logic [OPCODE_WIDTH-1:0] alu_opCode,
  input  logic [WORD_WIDTH-1:0]   alu_result,
  input  logic                    alu_zero_flag,
  // status
  output logic                    busy,
  output logic [15:0]             op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state;
  logic                    last_grant;
  logic                    grant_id;
  logic [WORD_WIDTH-1:0]   result_q;
  logic                    zero_q;

  logic                    sel_c;
  logic                    accept_c;
  logic                    resp_done_c;

  // Round-robin pick; ready only in IDLE and only for the winner.
  always_comb begin
    sel_c       = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    accept_c    = 1'b0;
    resp_done_c = 1'b0;
    if (req0_valid && req1_valid) begin
      sel_c = ~last_grant;
    end else begin
      sel_c = req1_valid;
    end
    if (state == IDLE) begin
      req0_ready = req0_valid && !sel_c;
      req1_ready = req1_valid && sel_c;
    end
    accept_c = req0_ready || req1_ready;
    if (state == RESP) begin
      resp_done_c = grant_id ? resp1_ready : resp0_ready;
    end
  end

  // Both ports see the single response register; only resp*_valid qualifies it.
  assign resp0_result    = result_q;
  assign resp1_result    = result_q;
  assign resp0_zero_flag = zero_q;
  assign resp1_zero_flag = zero_q;

  // Sequencer: accept -> one EXEC cycle -> RESP until the owner consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      grant_id     <= 1'b0;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      alu_opCode   <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      resp0_valid  <= 1'b0;
      resp1_valid  <= 1'b0;
      busy         <= 1'b0;
      op_count     <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            alu_operand1 <= sel_c ? req1_operand1 : req0_operand1;
            alu_operand2 <= sel_c ? req1_operand2 : req0_operand2;
            alu_opCode   <= sel_c ? req1_opCode   : req0_opCode;
            grant_id     <= sel_c;
            last_grant   <= sel_c;
            busy         <= 1'b1;
            state        <= EXEC;
          end
        end
        EXEC: begin
          result_q    <= alu_result;
          zero_q      <= alu_zero_flag;
          resp0_valid <= !grant_id;
          resp1_valid <= grant_id;
          state       <= RESP;
        end
        RESP: begin
          if (resp_done_c) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            busy        <= 1'b0;
            op_count    <= op_count + 16'd1;
            state       <= IDLE;
          end
        end
        default: begin
          resp0_valid <= 1'b0;
          resp1_valid <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
